clk_divider: RTL and testbench

- Programmable integer clock divider that consumes the buffered clock from the clock buffer stage.
- Produces a registered, glitch-free divided clock `clk_out` plus a one-cycle `tick` strobe aligned to each `clk_out` rising edge.
- Ratio changes and enable/disable take effect only at period boundaries, so downstream logic never sees a runt pulse.

---
 rtl/clk_divider.sv | 113 +++++++++++
 tb/tb_clk_divider.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// Programmable integer clock divider: registered glitch-free clk_out, tick strobe on each
// rising edge, and ratio/enable changes applied only at period boundaries.
module clk_divider #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  typedef enum logic {
    ST_PARKED,
    ST_RUN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] n_act, n_act_nxt;
  logic [CNT_W-1:0] pending, pending_nxt;
  logic             pending_vld, pending_vld_nxt;
  logic             clk_out_nxt, tick_nxt, ack_nxt, err_nxt;
  logic             load_ok, last_cnt, apply;
  logic [CNT_W-1:0] n_new, h_new;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    load_ok   = div_load && (div_val >= TWO);
    last_cnt  = (cnt == n_act - ONE);
    // A pending ratio is applied either immediately while parked or at the boundary edge.
    apply     = pending_vld && ((state == ST_PARKED) || last_cnt);
    n_new     = apply ? pending : n_act;
    h_new     = n_new - (n_new >> 1);

    state_nxt       = state;
    cnt_nxt         = cnt;
    n_act_nxt       = n_new;
    pending_nxt     = load_ok ? div_val : pending;
    pending_vld_nxt = load_ok || (pending_vld && !apply);
    tick_nxt        = 1'b0;
    ack_nxt         = apply;
    err_nxt         = div_load && (div_val < TWO);

    unique case (state)
      ST_PARKED: begin
        if (en) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          tick_nxt  = 1'b1;
        end else begin
          cnt_nxt = n_new - ONE;
        end
      end
      ST_RUN: begin
        if (!last_cnt) begin
          cnt_nxt = cnt + ONE;
        end else if (en) begin
          cnt_nxt  = '0;
          tick_nxt = 1'b1;
        end else begin
          state_nxt = ST_PARKED;
          cnt_nxt   = n_new - ONE;
        end
      end
      default: begin
        state_nxt = ST_PARKED;
        cnt_nxt   = n_new - ONE;
      end
    endcase

    clk_out_nxt = (state_nxt == ST_RUN) && (cnt_nxt < h_new);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: rst_n is expected to be released synchronously upstream; here it only asserts asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PARKED;
      cnt         <= DEF_N - ONE;
      n_act       <= DEF_N;
      pending     <= DEF_N;
      pending_vld <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      div_ack     <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      n_act       <= n_act_nxt;
      pending     <= pending_nxt;
      pending_vld <= pending_vld_nxt;
      clk_out     <= clk_out_nxt;
      tick        <= tick_nxt;
      div_ack     <= ack_nxt;
      div_err     <= err_nxt;
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_clk_divider.sv
// Scoreboard bench for clk_divider: directed per-cycle vectors push expected
// {clk_out, tick, running, div_ack, div_err}; a monitor pops and compares after each edge.
module tb_clk_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_ack, div_err, clk_out, tick, running;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  string      nm_q[$];

  clk_divider #(.CNT_W(8), .DEF_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (clk_out,tick,running,ack,err)", nm, act, exp);
    end
  endtask

  // One clk cycle of stimulus; exp is the output state right after the edge that samples it.
  task automatic step(input logic e, input logic ld, input logic [7:0] v,
                      input logic [4:0] exp, input string nm);
    @(negedge clk);
    en       = e;
    div_load = ld;
    div_val  = v;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
  endtask

  // One full period of ratio n with en held high, starting at a boundary edge.
  task automatic run_period(input int n, input bit ack_first, input bit ld_first,
                            input logic [7:0] v, input string nm);
    for (int c = 0; c < n; c++) begin
      step(1'b1, ld_first && (c == 0), v,
           {(c < (n - n / 2)), (c == 0), 1'b1, ack_first && (c == 0), 1'b0},
           $sformatf("%s_c%0d", nm, c));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      string      n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      check(n, {3'b000, clk_out, tick, running, div_ack, div_err}, {3'b000, e});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
    #2;
    check("reset", {3'b000, clk_out, tick, running, div_ack, div_err}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Start from parked at DEF_DIV=4: 1100 repeating, tick on each rise
    for (int k = 0; k < 3; k++) run_period(4, 0, 0, 0, "n4");

    // Load 5 mid-period: current 4-period completes, ack at next boundary, then 11100
    step(1, 0, 0, 5'b11100, "ld5_c0");
    step(1, 1, 5, 5'b10100, "ld5_c1");
    step(1, 0, 0, 5'b00100, "ld5_c2");
    step(1, 0, 0, 5'b00100, "ld5_c3");
    run_period(5, 1, 0, 0, "n5_ack");
    run_period(5, 0, 0, 0, "n5");

    // Illegal ratios 1 and 0: div_err each following cycle, ratio unchanged, no ack
    step(1, 0, 0, 5'b11100, "err_c0");
    step(1, 1, 1, 5'b10101, "err_v1");
    step(1, 1, 0, 5'b10101, "err_v0");
    step(1, 0, 0, 5'b00100, "err_c3");
    step(1, 0, 0, 5'b00100, "err_c4");
    run_period(5, 0, 0, 0, "n5_noack");

    // Back-to-back loads 6 then 3: last wins, single ack, then 110
    step(1, 0, 0, 5'b11100, "l63_c0");
    step(1, 1, 6, 5'b10100, "l63_c1");
    step(1, 1, 3, 5'b10100, "l63_c2");
    step(1, 0, 0, 5'b00100, "l63_c3");
    step(1, 0, 0, 5'b00100, "l63_c4");
    run_period(3, 1, 0, 0, "n3_ack");
    run_period(3, 0, 0, 0, "n3");

    // Load sampled on the boundary edge itself applies one boundary later
    run_period(3, 0, 1, 4, "bnd_ld");
    run_period(4, 1, 0, 0, "n4_ack");

    // en dropped then restored before the boundary: no gap
    step(1, 0, 0, 5'b11100, "cancel_c0");
    step(0, 0, 0, 5'b10100, "cancel_c1");
    step(0, 0, 0, 5'b00100, "cancel_c2");
    step(1, 0, 0, 5'b00100, "cancel_c3");
    run_period(4, 0, 0, 0, "cancel_next");

    // Stop at cnt=1: period finishes, then parked with clk_out low
    step(1, 0, 0, 5'b11100, "stop_c0");
    step(1, 0, 0, 5'b10100, "stop_c1");
    step(0, 0, 0, 5'b00100, "stop_c2");
    step(0, 0, 0, 5'b00100, "stop_c3");
    step(0, 0, 0, 5'b00000, "stop_bnd");
    step(0, 0, 0, 5'b00000, "stop_hold");

    // Load while parked applies on the next edge; restart rises immediately
    step(0, 1, 3, 5'b00000, "park_ld");
    step(0, 0, 0, 5'b00010, "park_ack");
    run_period(3, 0, 0, 0, "restart_n3");

    // Load and stop together: ack on the stop boundary, running drops same edge
    step(1, 0, 0, 5'b11100, "ldstop_c0");
    step(0, 1, 5, 5'b10100, "ldstop_c1");
    step(0, 0, 0, 5'b00100, "ldstop_c2");
    step(0, 0, 0, 5'b00010, "ldstop_bnd");
    run_period(5, 0, 0, 0, "restart_n5");

    // Reset mid-high phase of N=5 with a load pending
    step(1, 0, 0, 5'b11100, "rst_c0");
    step(1, 1, 3, 5'b10100, "rst_c1");
    step(1, 0, 0, 5'b10100, "rst_c2");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en = 1'b0; div_load = 1'b0; div_val = '0;
    #1;
    check("reset_mid", {3'b000, clk_out, tick, running, div_ack, div_err}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 5'b00000, "post_rst_park");
    run_period(4, 0, 0, 0, "post_rst_n4a");
    run_period(4, 0, 0, 0, "post_rst_n4b");

    @(posedge clk);
    #3;
    check("drain", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
